// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha keystream XOR stage: block width,
// controller state encoding and keystream word selection.
package chacha_pkg;

    localparam int unsigned KS_BLOCK_W    = 512;
    // Widest supported stream word; ks_word returns this many bits.
    localparam int unsigned KS_WORD_MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RUN  = 2'd3
    } xor_state_t;

    // Word idx of a keystream block, right-aligned in a KS_WORD_MAX_W field.
    function automatic logic [KS_WORD_MAX_W-1:0] ks_word(
        input logic [KS_BLOCK_W-1:0] blk,
        input int unsigned           idx,
        input int unsigned           word_w
    );
        logic [KS_BLOCK_W-1:0] shifted;
        shifted = blk >> (idx * word_w);
        return shifted[KS_WORD_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/chacha_xor_outreg.sv
// One-entry valid/ready output register: full throughput, data held stable
// while stalled.
module chacha_xor_outreg #(
    parameter int unsigned WORD_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);

    // Load on handshake, drain on out_ready, drop on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha_xor_stream.sv
// Keystream consumer: requests one 512-bit ChaCha block at a time, XORs it
// word by word onto the data stream and discards leftovers at message end.
module chacha_xor_stream
    import chacha_pkg::*;
#(
    parameter int unsigned WORD_W     = 128,
    parameter int unsigned KS_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    output logic                  ks_req,
    input  logic                  ks_valid,
    input  logic [KS_BLOCK_W-1:0] ks_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_data,
    input  logic [WORD_W/8-1:0]   in_keep,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_last,
    output logic [31:0]           ks_blocks
);

    localparam int unsigned WPB    = KS_BLOCK_W / WORD_W;
    localparam int unsigned NBYTES = WORD_W / 8;
    localparam int unsigned IDX_W  = $clog2(WPB);
    localparam int unsigned TMR_W  = $clog2(KS_TIMEOUT);

    xor_state_t                 state;
    logic [KS_BLOCK_W-1:0]      ks_buf;
    logic                       buf_full;
    logic [IDX_W-1:0]           idx;
    logic [TMR_W-1:0]           timer;
    logic                       hs;
    logic [KS_WORD_MAX_W-1:0]   ks_sel;
    logic [WORD_W-1:0]          xor_word;

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign hs       = in_valid && in_ready;

    // Select the current keystream word, XOR it in and zero disabled bytes
    always_comb begin
        ks_sel   = ks_word(ks_buf, 32'(idx), WORD_W);
        xor_word = in_data ^ ks_sel[WORD_W-1:0];
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (!in_keep[b]) begin
                xor_word[8*b +: 8] = '0;
            end
        end
    end

    // Request/capture controller; ks_req is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ks_req    <= 1'b0;
            ks_buf    <= '0;
            buf_full  <= 1'b0;
            idx       <= '0;
            timer     <= '0;
            ks_blocks <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            ks_req    <= 1'b0;
            buf_full  <= 1'b0;
            idx       <= '0;
            timer     <= '0;
            ks_blocks <= '0;
        end else begin
            ks_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && !buf_full) begin
                        state  <= ST_REQ;
                        ks_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ks_valid) begin
                        ks_buf    <= ks_data;
                        buf_full  <= 1'b1;
                        idx       <= '0;
                        ks_blocks <= ks_blocks + 32'd1;
                        state     <= ST_RUN;
                    end else if (timer == TMR_W'(KS_TIMEOUT - 1)) begin
                        // Producer never answered: re-issue the request
                        timer  <= '0;
                        ks_req <= 1'b1;
                        state  <= ST_REQ;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        if (in_last) begin
                            idx      <= '0;
                            buf_full <= 1'b0;
                            state    <= ST_IDLE;
                        end else if (idx == IDX_W'(WPB - 1)) begin
                            // Block exhausted mid-message: prefetch the next one
                            idx      <= '0;
                            buf_full <= 1'b0;
                            ks_req   <= 1'b1;
                            state    <= ST_REQ;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    chacha_xor_outreg #(
        .WORD_W(WORD_W)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (hs),
        .load_data (xor_word),
        .load_last (in_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: doc/chacha_xor_stream.md
Name: chacha_xor_stream

Overview:
- Consumer side of the keystream request/valid interface. It issues single-cycle keystream requests, buffers one 512-bit block, and XORs it word by word with an incoming plaintext or ciphertext stream.
- Sits between the datapath stream and the ChaCha keystream unit in the PIM AEAD path. It performs encryption and decryption identically.
- Discards unused keystream at message end, so every message starts on a fresh block.

Parameters:
WORD_W, 128, stream word width in bits; legal values are 32, 64, 128. WPB = 512/WORD_W.
KS_TIMEOUT, 64, cycles to wait for ks_valid before re-issuing ks_req; minimum 8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; drops the buffer and any pending request
ks_req  out  1  single-cycle keystream request pulse
ks_valid  in  1  keystream block valid, single-cycle
ks_data  in  512  keystream block
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  WORD_W  input word
in_keep  in  WORD_W/8  byte enables; bit b covers in_data[8b+7:8b]
in_last  in  1  last word of message
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  WORD_W  in_data XOR keystream word, with disabled bytes forced to 0
out_last  out  1  registered copy of in_last
ks_blocks  out  32  count of keystream blocks received since reset or flush; wraps

Behaviour:
- Reset values: every output is 0, FSM is IDLE, buffer is empty, word index is 0.
- FSM states are IDLE, REQ, WAIT and RUN.
- IDLE -> REQ when in_valid=1 and the buffer is empty.
- REQ: ks_req=1 for exactly one cycle, timer cleared, then -> WAIT.
- WAIT: ks_valid=1 captures ks_data into ks_buf, sets idx=0, increments ks_blocks, -> RUN.
- WAIT timeout: the timer reaching KS_TIMEOUT-1 without ks_valid sends the FSM to REQ, giving a retry pulse. This covers a request dropped while the producer is busy.
- ks_valid arriving outside WAIT is ignored. The block is not captured and ks_blocks does not increment.
- RUN: in_ready = !out_valid || out_ready. The registered output stage is a one-entry pipe with full throughput.
- On handshake: out_data = (in_data ^ ks_buf[WORD_W*idx +: WORD_W]) with bytes zeroed wherever in_keep=0. Also out_last <= in_last and out_valid <= 1.
- Index update on a handshake:
  - in_last=1: idx <= 0, buffer marked empty, -> IDLE. The remaining keystream words are discarded.
  - else idx = WPB-1: buffer empty, -> REQ, which prefetches the next block with no bubble beyond the request latency.
  - else idx <= idx+1.
- in_ready is 0 in IDLE, REQ and WAIT, so no word is accepted without keystream.
- out_valid holds, with data stable, until out_ready. It clears on out_ready when no new handshake occurs in the same cycle.
- flush: highest priority. Next cycle the FSM is IDLE, buffer empty, idx 0, timer 0, ks_blocks 0, out_valid 0. A ks_valid coinciding with flush is dropped.
- Simultaneous last word and idx=WPB-1: the in_last rule wins, and no request is issued.
- Async reset mid-operation returns everything to reset values immediately. No ks_req is issued until rst_n deasserts and in_valid arrives.
- Single-word message: one request, one word consumed, the rest of the block is discarded.

Decomposition:
- Shared package chacha_pkg:
  - KS_BLOCK_W = 512
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2, RUN=3)
  - function ks_word(buf, idx) for word selection
- One natural sub-module, chacha_xor_outreg: the one-entry valid/ready output register holding out_data and out_last. All other logic lives in the top module.

Test Plan:
- Single-cycle ks_req check: in_valid with 4 words of 0x00..0 and ks_data = 512'h0123…(incrementing bytes) delivered 5 cycles after ks_req -> exactly one ks_req pulse; out_data words equal ks_data[127:0], [255:128], [383:256], [511:384]; ks_blocks=1.
- Prefetch without stall: 6-word message, keep all-ones, last on word 6 -> ks_req re-issued the cycle after word 4 is accepted; words 5–6 XOR with block 2 words 0–1; FSM IDLE after word 6. Next message triggers a new request, showing block 2 words 2–3 were discarded.
- Backpressure and partial keep: out_ready held 0 for 10 cycles -> out_data/out_valid stable and in_ready=0 throughout. Last word with in_keep=16'h00FF -> out_data[127:64]=0, out_last=1.
- Dropped request retry: no ks_valid for KS_TIMEOUT cycles -> second ks_req exactly KS_TIMEOUT+1 cycles after the first. A stray ks_valid in RUN does not change ks_buf or ks_blocks.
- Flush and reset: flush mid-block with out_valid=1 -> next cycle out_valid=0, ks_blocks=0, and the following message requests a fresh block. rst_n pulsed low in WAIT -> all outputs 0, no ks_req until new in_valid.
- Round-trip: encrypt a 7-word random message, feed the output back through with the same keystream blocks -> original plaintext recovered on every enabled byte.
